usbfs_tx_sched: RTL and testbench
=================================

Name: usbfs_tx_sched

Overview:
- Transmit scheduler in front of the USB FS device packet sender. It shares the single packet-level TX port between two kinds of requester:
  - one handshake requester (ACK/NAK/STALL), at fixed highest priority;
  - NUM_SRC data-packet requesters (IN endpoints / control responses), served round-robin.
- Issues the tp_sta pulse and PID, steers the byte-request/byte/fin_n stream to the granted source, and reports completion back to it.

Parameters:
- NUM_SRC, 2, number of data requesters (1..8).
- GAP_CYCLES, 16, minimum idle clk cycles between pkt_done and the next tp_sta (used only with the optional feature).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- hs_req  in  1  handshake request, level; held until hs_gnt
- hs_pid  in  4  handshake PID; valid while hs_req=1
- hs_gnt  out  1  one-cycle grant pulse, coincident with tp_sta
- hs_done  out  1  one-cycle pulse when the handshake packet has finished
- src_req  in  NUM_SRC  data requests, level; each dropped on its src_gnt
- src_pid  in  4*NUM_SRC  per-source PID; source i uses bits [4i+3:4i]
- src_gnt  out  NUM_SRC  one-hot one-cycle grant pulse, coincident with tp_sta
- src_byte_req  out  NUM_SRC  byte request, routed to the owner
- src_byte  in  8*NUM_SRC  per-source byte; valid the cycle after its src_byte_req
- src_fin_n  in  NUM_SRC  per-source "more data" flag; low = payload exhausted
- src_done  out  NUM_SRC  one-hot one-cycle completion pulse
- tp_sta  out  1  packet start pulse to the packet sender
- tp_pid  out  4  PID to the packet sender; stable from tp_sta until the next grant
- tp_byte_req  in  1  byte request from the packet sender
- tp_byte  out  8  byte to the packet sender
- tp_fin_n  out  1  fin_n to the packet sender
- pkt_done  in  1  one-cycle end-of-packet pulse; tied to the sender's tx_fin
- busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, BUSY, GAP (GAP exists only with the optional feature).
- Reset (async, rstn=0): all outputs 0; state IDLE; tp_pid=0; round-robin pointer rr_ptr=0; owner cleared. Reset mid-packet abandons the packet silently and issues no done pulse.
- IDLE, arbitration on registered inputs:
  - hs_req=1: owner=HS, tp_pid<=hs_pid, tp_sta<=1 and hs_gnt<=1 next cycle, go to BUSY.
  - else any src_req: winner is the first set bit scanning from rr_ptr upward, wrapping modulo NUM_SRC. owner=winner, tp_pid<=src_pid[winner], tp_sta<=1 and src_gnt[winner]<=1 next cycle, rr_ptr<=(winner+1) mod NUM_SRC, go to BUSY.
  - Latency: request sampled in cycle T -> tp_sta/gnt high in cycle T+1.
- BUSY:
  - Data owner (combinational steering):
    - src_byte_req[owner]=tp_byte_req;
    - tp_byte=src_byte[owner*8+:8];
    - tp_fin_n=src_fin_n[owner].
  - HS owner:
    - tp_byte=0 and tp_fin_n=0;
    - no src_byte_req is driven; a tp_byte_req is ignored.
  - Non-owners always see src_byte_req=0.
  - Requests are not re-arbitrated. An owner dropping its req does not abort the packet. New hs_req waits.
  - On pkt_done: next cycle pulse hs_done or src_done[owner], and go to IDLE (or GAP when the feature is enabled).
- A src_req still high in IDLE is a new request; requesters must drop req on gnt.
- Outside BUSY: tp_byte=0, tp_fin_n=0, src_byte_req=0.
- pkt_done outside BUSY is ignored.
- pkt_done coincident with a new request: the new request is arbitrated in the first IDLE cycle, so the earliest next tp_sta is 2 cycles after pkt_done.
- Handshake PIDs must have pid[1:0]!=2'b11, so the sender requests no bytes for them.

Optional Feature:
- Macro: USBFS_TX_GAP_EN.
- Defined:
  - after pkt_done the block enters GAP and counts GAP_CYCLES cycles with a counter wide enough to hold GAP_CYCLES, then returns to IDLE;
  - busy stays 1 during GAP;
  - requests pending during GAP are held and arbitrated on return to IDLE.
- Undefined: the BUSY->IDLE transition is direct and there is no counter logic.

Test Plan:
- HS only: hs_req=1, hs_pid=4'h2 -> next cycle tp_sta=1, hs_gnt=1, tp_pid=2; tp_fin_n=0 throughout; pkt_done -> hs_done pulse 1 cycle later; busy returns to 0.
- Data packet: src_req[0]=1, src_pid=4'h3, 3 bytes 0x11,0x22,0x33 then fin_n=0 -> tp_byte follows src_byte each request; src_byte_req[1] stays 0; src_done[0] pulses after pkt_done.
- Priority and round-robin: src_req=2'b11 with hs_req=1 in the same cycle -> HS granted first, then src 0, then src 1; src_req=2'b11 again -> src 0 next (rr_ptr wrapped).
- Mid-packet: hs_req asserted during a src 1 packet -> no grant until pkt_done; HS grant follows 2 cycles after pkt_done.
- Reset mid-packet: rstn low while BUSY -> all outputs 0 immediately, no done pulse; after release a new src_req is granted normally with rr_ptr=0.
- Gap (USBFS_TX_GAP_EN, GAP_CYCLES=16): src_req high at pkt_done -> next tp_sta no earlier than 18 cycles after pkt_done; busy=1 throughout.

Source files
------------

// File: rtl/usbfs_tx_sched.sv
// usbfs_tx_sched: shares the packet-level USB FS transmit port between one
// handshake requester (fixed highest priority) and NUM_SRC data requesters
// (round-robin). It issues tp_sta/tp_pid, steers the byte stream to the
// current owner and pulses a done back to it once the packet has been sent.
//
// Optional build macro USBFS_TX_GAP_EN: after each packet the scheduler
// holds off for GAP_CYCLES idle cycles (state GAP) before arbitrating again.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no packet in flight; arbitrate hs_req first, then src_req by rr_ptr
// BUSY  | packet in flight for owner; wait for pkt_done
// GAP   | (USBFS_TX_GAP_EN only) inter-packet hold-off, busy stays high
module usbfs_tx_sched #(
   parameter int NUM_SRC    = 2,
   parameter int GAP_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   hs_req,
   input  logic [3:0]             hs_pid,
   output logic                   hs_gnt,
   output logic                   hs_done,
   input  logic [NUM_SRC-1:0]     src_req,
   input  logic [4*NUM_SRC-1:0]   src_pid,
   output logic [NUM_SRC-1:0]     src_gnt,
   output logic [NUM_SRC-1:0]     src_byte_req,
   input  logic [8*NUM_SRC-1:0]   src_byte,
   input  logic [NUM_SRC-1:0]     src_fin_n,
   output logic [NUM_SRC-1:0]     src_done,
   output logic                   tp_sta,
   output logic [3:0]             tp_pid,
   input  logic                   tp_byte_req,
   output logic [7:0]             tp_byte,
   output logic                   tp_fin_n,
   input  logic                   pkt_done,
   output logic                   busy
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1
`ifdef USBFS_TX_GAP_EN
      , GAP = 2'd2
`endif
   } state_t;

   state_t          state;
   logic            owner_hs;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   rr_ptr;

`ifdef USBFS_TX_GAP_EN
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   logic [GW-1:0]   gap_cnt;
`endif

   logic [3:0]      pid_arr  [NUM_SRC];
   logic [7:0]      byte_arr [NUM_SRC];
   logic [NUM_SRC-1:0] win_onehot;
   logic [NUM_SRC-1:0] own_onehot;

   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic [IW-1:0]   next_ptr;
   logic            found;
   int              sum;
   logic            data_own;

   // Per-source field unpacking and one-hot decodes of winner and owner.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign pid_arr[g]    = src_pid[4*g +: 4];
      assign byte_arr[g]   = src_byte[8*g +: 8];
      assign win_onehot[g] = found && (win_idx == IW'(g));
      assign own_onehot[g] = (owner == IW'(g));
   end

   // Round-robin search: first requesting source at or after rr_ptr, wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      sum     = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= NUM_SRC) sum = sum - NUM_SRC;
         cand = IW'(sum);
         if (!found && src_req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign next_ptr = (win_idx == IW'(NUM_SRC - 1)) ? '0 : win_idx + IW'(1);
   assign data_own = (state == BUSY) && !owner_hs;
   assign busy     = (state != IDLE);

   // Byte stream steering: only a data owner in BUSY connects to the sender.
   always_comb begin
      tp_byte      = '0;
      tp_fin_n     = 1'b0;
      src_byte_req = '0;
      if (data_own) begin
         tp_byte      = byte_arr[owner];
         tp_fin_n     = src_fin_n[owner];
         src_byte_req = own_onehot & {NUM_SRC{tp_byte_req}};
      end
   end

   // Scheduler FSM with registered grant/start/done pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         owner_hs <= 1'b0;
         owner    <= '0;
         rr_ptr   <= '0;
         tp_pid   <= '0;
         tp_sta   <= 1'b0;
         hs_gnt   <= 1'b0;
         src_gnt  <= '0;
         hs_done  <= 1'b0;
         src_done <= '0;
`ifdef USBFS_TX_GAP_EN
         gap_cnt  <= '0;
`endif
      end else begin
         tp_sta   <= 1'b0;
         hs_gnt   <= 1'b0;
         src_gnt  <= '0;
         hs_done  <= 1'b0;
         src_done <= '0;
         case (state)
            IDLE: begin
               if (hs_req) begin
                  owner_hs <= 1'b1;
                  tp_pid   <= hs_pid;
                  tp_sta   <= 1'b1;
                  hs_gnt   <= 1'b1;
                  state    <= BUSY;
               end else if (found) begin
                  owner_hs <= 1'b0;
                  owner    <= win_idx;
                  tp_pid   <= pid_arr[win_idx];
                  tp_sta   <= 1'b1;
                  src_gnt  <= win_onehot;
                  rr_ptr   <= next_ptr;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (pkt_done) begin
                  if (owner_hs) hs_done  <= 1'b1;
                  else          src_done <= own_onehot;
`ifdef USBFS_TX_GAP_EN
                  if (GAP_CYCLES > 0) begin
                     gap_cnt <= GW'(GAP_CYCLES - 1);
                     state   <= GAP;
                  end else begin
                     state   <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end
`ifdef USBFS_TX_GAP_EN
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - GW'(1);
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usbfs_tx_sched.sv
// Directed bench for usbfs_tx_sched (NUM_SRC=2): a per-cycle vector table for
// handshake, data steering, priority and round-robin, then hand sequences for
// a handshake held off by a data packet and for reset mid-packet.
module tb_usbfs_tx_sched;

`ifdef USBFS_TX_GAP_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rstn;
   logic        hs_req;
   logic [3:0]  hs_pid;
   logic        hs_gnt;
   logic        hs_done;
   logic [1:0]  src_req;
   logic [7:0]  src_pid;
   logic [1:0]  src_gnt;
   logic [1:0]  src_byte_req;
   logic [15:0] src_byte;
   logic [1:0]  src_fin_n;
   logic [1:0]  src_done;
   logic        tp_sta;
   logic [3:0]  tp_pid;
   logic        tp_byte_req;
   logic [7:0]  tp_byte;
   logic        tp_fin_n;
   logic        pkt_done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   usbfs_tx_sched #(.NUM_SRC(2), .GAP_CYCLES(16)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .hs_req       (hs_req),
      .hs_pid       (hs_pid),
      .hs_gnt       (hs_gnt),
      .hs_done      (hs_done),
      .src_req      (src_req),
      .src_pid      (src_pid),
      .src_gnt      (src_gnt),
      .src_byte_req (src_byte_req),
      .src_byte     (src_byte),
      .src_fin_n    (src_fin_n),
      .src_done     (src_done),
      .tp_sta       (tp_sta),
      .tp_pid       (tp_pid),
      .tp_byte_req  (tp_byte_req),
      .tp_byte      (tp_byte),
      .tp_fin_n     (tp_fin_n),
      .pkt_done     (pkt_done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      logic        hr;
      logic [3:0]  hp;
      logic [1:0]  sr;
      logic        br;
      logic [15:0] sb;
      logic [1:0]  fn;
      logic        pd;
      logic [22:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Expected order: tp_sta, hs_gnt, src_gnt, hs_done, src_done, tp_pid,
   // tp_byte, tp_fin_n, src_byte_req, busy.
   function automatic logic [22:0] obs();
      return {tp_sta, hs_gnt, src_gnt, hs_done, src_done, tp_pid,
              tp_byte, tp_fin_n, src_byte_req, busy};
   endfunction

   function automatic vec_t v(
      input logic hr, input logic [3:0] hp, input logic [1:0] sr,
      input logic br, input logic [15:0] sb, input logic [1:0] fn,
      input logic pd,
      input logic sta, input logic hg, input logic [1:0] sg,
      input logic hd, input logic [1:0] sd, input logic [3:0] pid,
      input logic [7:0] tb, input logic tf, input logic [1:0] sbr,
      input logic bz);
      vec_t r;
      r.hr = hr; r.hp = hp; r.sr = sr; r.br = br;
      r.sb = sb; r.fn = fn; r.pd = pd;
      r.exp = {sta, hg, sg, hd, sd, pid, tb, tf, sbr, bz};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      hs_req      = 1'b0;
      hs_pid      = 4'h0;
      src_req     = 2'b00;
      src_byte    = 16'h0000;
      src_fin_n   = 2'b00;
      tp_byte_req = 1'b0;
      pkt_done    = 1'b0;
   endtask

   initial begin
      logic got;
      logic sd_seen;
      int   lat;
      int   bad;
      int   busy_low;

      rstn    = 1'b0;
      src_pid = 8'hB3;
      idle_inputs();
      #3;
      check("reset_outputs", 32'(obs()), 32'h0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

`ifndef USBFS_TX_GAP_EN
      //         hr  hp    sr    br  sb        fn    pd   sta hg  sg    hd  sd    pid   tb    tf  sbr   bz
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'h0,8'h00,'0,2'b00,'0));
      tbl.push_back(v('1,4'h2,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'h0,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '1,'1,2'b00,'0,2'b00,4'h2,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'1,16'h3344,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h2,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'1, '0,'0,2'b00,'0,2'b00,4'h2,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'1,2'b00,4'h2,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'h2,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b01,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'h2,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '1,'0,2'b01,'0,2'b00,4'h3,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'1,16'hEE00,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h00,'1,2'b01,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'hEE11,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h11,'1,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'1,16'hEE11,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h11,'1,2'b01,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'hEE22,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h22,'1,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'1,16'hEE22,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h22,'1,2'b01,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'hEE33,2'b10,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h33,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'hEE33,2'b10,'1, '0,'0,2'b00,'0,2'b00,4'h3,8'h33,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b01,4'h3,8'h00,'0,2'b00,'0));
      tbl.push_back(v('1,4'hA,2'b11,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'h3,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'0, '1,'1,2'b00,'0,2'b00,4'hA,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'1, '0,'0,2'b00,'0,2'b00,4'hA,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'1,2'b00,4'hA,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b01,'0,16'h0000,2'b00,'0, '1,'0,2'b10,'0,2'b00,4'hB,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b01,'1,16'h4455,2'b11,'0, '0,'0,2'b00,'0,2'b00,4'hB,8'h44,'1,2'b10,'1));
      tbl.push_back(v('0,4'h0,2'b01,'0,16'h4455,2'b01,'1, '0,'0,2'b00,'0,2'b00,4'hB,8'h44,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b01,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b10,4'hB,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'0, '1,'0,2'b01,'0,2'b00,4'h3,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'1, '0,'0,2'b00,'0,2'b00,4'h3,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b11,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b01,4'h3,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '1,'0,2'b10,'0,2'b00,4'hB,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'1, '0,'0,2'b00,'0,2'b00,4'hB,8'h00,'0,2'b00,'1));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b10,4'hB,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'1, '0,'0,2'b00,'0,2'b00,4'hB,8'h00,'0,2'b00,'0));
      tbl.push_back(v('0,4'h0,2'b00,'0,16'h0000,2'b00,'0, '0,'0,2'b00,'0,2'b00,4'hB,8'h00,'0,2'b00,'0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         hs_req      = tbl[i].hr;
         hs_pid      = tbl[i].hp;
         src_req     = tbl[i].sr;
         tp_byte_req = tbl[i].br;
         src_byte    = tbl[i].sb;
         src_fin_n   = tbl[i].fn;
         pkt_done    = tbl[i].pd;
         @(negedge clk);
         check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
      end
`endif

      // Handshake raised during a src 1 packet must wait for pkt_done.
      @(posedge clk);
      #1;
      idle_inputs();
      src_req = 2'b10;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (src_gnt[1]) begin
            got = 1'b1;
            break;
         end
      end
      check("mid_src1_gnt", 32'(got), 32'h1);
      check("mid_src1_pid", 32'(tp_pid), 32'hB);
      src_req = 2'b00;
      hs_req  = 1'b1;
      hs_pid  = 4'h2;
      bad = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (hs_gnt || tp_sta) bad++;
      end
      check("mid_hs_held", 32'(bad), 32'h0);
      @(posedge clk);
      #1 pkt_done = 1'b1;
      @(negedge clk);
      check("mid_no_gnt_at_done", 32'(hs_gnt), 32'h0);
      lat      = 0;
      sd_seen  = 1'b0;
      busy_low = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1 pkt_done = 1'b0;
         @(negedge clk);
         if (k == 1 && src_done == 2'b10) sd_seen = 1'b1;
         if (k <= 16 && !busy) busy_low++;
         if (hs_gnt) begin
            lat = k;
            break;
         end
      end
      check("mid_src_done", 32'(sd_seen), 32'h1);
      check("mid_hs_latency", 32'(lat), 32'(LAT));
`ifdef USBFS_TX_GAP_EN
      check("gap_busy_held", 32'(busy_low), 32'h0);
`endif
      check("mid_hs_pid", 32'(tp_pid), 32'h2);
      hs_req = 1'b0;
      @(posedge clk);
      #1 pkt_done = 1'b1;
      @(posedge clk);
      #1 pkt_done = 1'b0;
      @(negedge clk);
      check("mid_hs_done", 32'(hs_done), 32'h1);

      // Grant src 0 (rr_ptr moves to 1), then reset in the middle of it.
      @(posedge clk);
      #1 src_req = 2'b01;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (src_gnt[0]) begin
            got = 1'b1;
            break;
         end
      end
      check("rst_src0_gnt", 32'(got), 32'h1);
      src_req     = 2'b00;
      tp_byte_req = 1'b1;
      src_byte    = 16'h005A;
      src_fin_n   = 2'b01;
      #1;
      check("rst_pre_steer", 32'({src_byte_req, tp_byte, tp_fin_n, busy}),
            32'({2'b01, 8'h5A, 1'b1, 1'b1}));
      #2 rstn = 1'b0;
      #1;
      check("rst_async_clear", 32'(obs()), 32'h0);
      pkt_done = 1'b1;
      @(posedge clk);
      #1;
      rstn        = 1'b1;
      tp_byte_req = 1'b0;
      src_byte    = 16'h0000;
      src_fin_n   = 2'b00;
      @(posedge clk);
      #1;
      pkt_done = 1'b0;
      src_req  = 2'b11;
      @(negedge clk);
      check("rst_no_done", 32'({hs_done, src_done, busy, tp_sta}), 32'h0);
      @(posedge clk);
      #1 src_req = 2'b00;
      @(negedge clk);
      check("rst_rr_ptr0", 32'({tp_sta, src_gnt, tp_pid}), 32'({1'b1, 2'b01, 4'h3}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
